// File: rtl/store_align_unit.sv
// store_align_unit
//
// Store-path alignment unit. It accepts a RISC-V store (SB/SH/SW) from the core
// and computes the word address, the byte enables and the lane-aligned write data.
// It drives a request/acknowledge write port on data memory and holds each beat
// until memory acknowledges it.
//
// Optional feature: define STORE_SPLIT_MISALIGNED_EN to accept misaligned SH/SW at
// any offset. A store that crosses a word boundary is then issued as two word writes.
// In the default build, misaligned SH/SW are rejected with st_err.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   st_valid/st_ready  core store handshake (ready only while idle)
//   st_type            funct3[1:0]: 00 SB, 01 SH, 10 SW, 11 illegal
//   st_addr, st_wdata  byte address and rs2 value
//   mem_req/mem_ack    memory write handshake, request held until ack
//   mem_addr           word-aligned address of the current beat
//   mem_be, mem_wdata  byte enables and lane-aligned data (0 when idle)
//   st_done, st_err    one-cycle completion pulse, err qualifies rejection

module store_align_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        st_done,
    output logic        st_err
);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;

    state_e      state_q, state_d;
    logic [29:0] word_q, word_d;
    logic [3:0]  be0_q, be0_d;
    logic [31:0] wd0_q, wd0_d;
    logic        err_q, err_d;

    logic [1:0]  off;
    logic [3:0]  base_mask;
    logic [31:0] size_data;
    logic [3:0]  lane_be0;
    logic [31:0] lane_wd0;
    logic        illegal;

`ifdef STORE_SPLIT_MISALIGNED_EN
    logic [3:0]  be1_q, be1_d;
    logic [31:0] wd1_q, wd1_d;
    logic [3:0]  lane_be1;
    logic [31:0] lane_wd1;
    logic [7:0]  mask8;
    logic [63:0] data64;
`endif

    // Decode of the incoming store; only consumed on the accept edge.
    always_comb begin
        off       = st_addr[1:0];
        base_mask = 4'b0000;
        size_data = 32'h0;
        case (st_type)
            2'b00: begin
                base_mask = 4'b0001;
                size_data = {24'h0, st_wdata[7:0]};
            end
            2'b01: begin
                base_mask = 4'b0011;
                size_data = {16'h0, st_wdata[15:0]};
            end
            2'b10: begin
                base_mask = 4'b1111;
                size_data = st_wdata;
            end
            default: begin
                base_mask = 4'b0000;
                size_data = 32'h0;
            end
        endcase

`ifdef STORE_SPLIT_MISALIGNED_EN
        mask8    = {4'b0000, base_mask} << off;
        data64   = {32'h0, size_data} << {off, 3'b000};
        lane_be0 = mask8[3:0];
        lane_be1 = mask8[7:4];
        lane_wd0 = data64[31:0];
        lane_wd1 = data64[63:32];
        illegal  = (st_type == 2'b11);
`else
        // Legal stores never cross a word here, so a 4-bit shift loses nothing.
        lane_be0 = base_mask << off;
        lane_wd0 = size_data << {off, 3'b000};
        illegal  = (st_type == 2'b11) ||
                   ((st_type == 2'b01) && off[0]) ||
                   ((st_type == 2'b10) && (off != 2'b00));
`endif
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        be0_d   = be0_q;
        wd0_d   = wd0_q;
        err_d   = err_q;
`ifdef STORE_SPLIT_MISALIGNED_EN
        be1_d   = be1_q;
        wd1_d   = wd1_q;
`endif
        case (state_q)
            StIdle: begin
                if (st_valid) begin
                    word_d  = st_addr[31:2];
                    be0_d   = lane_be0;
                    wd0_d   = lane_wd0;
                    err_d   = illegal;
`ifdef STORE_SPLIT_MISALIGNED_EN
                    be1_d   = lane_be1;
                    wd1_d   = lane_wd1;
`endif
                    state_d = illegal ? StDone : StBeat0;
                end
            end
            StBeat0: begin
                if (mem_ack) begin
`ifdef STORE_SPLIT_MISALIGNED_EN
                    state_d = (be1_q != 4'b0000) ? StBeat1 : StDone;
`else
                    state_d = StDone;
`endif
                end
            end
            StBeat1: begin
`ifdef STORE_SPLIT_MISALIGNED_EN
                if (mem_ack) begin
                    state_d = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            word_q  <= 30'h0;
            be0_q   <= 4'h0;
            wd0_q   <= 32'h0;
            err_q   <= 1'b0;
`ifdef STORE_SPLIT_MISALIGNED_EN
            be1_q   <= 4'h0;
            wd1_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            be0_q   <= be0_d;
            wd0_q   <= wd0_d;
            err_q   <= err_d;
`ifdef STORE_SPLIT_MISALIGNED_EN
            be1_q   <= be1_d;
            wd1_q   <= wd1_d;
`endif
        end
    end

    // Outputs are decoded from registered state only; memory fields are zero off-beat.
    always_comb begin
        st_ready  = (state_q == StIdle);
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        st_done   = 1'b0;
        st_err    = 1'b0;
        case (state_q)
            StBeat0: begin
                mem_req   = 1'b1;
                mem_addr  = {word_q, 2'b00};
                mem_be    = be0_q;
                mem_wdata = wd0_q;
            end
`ifdef STORE_SPLIT_MISALIGNED_EN
            StBeat1: begin
                mem_req   = 1'b1;
                // 30-bit increment wraps 0xFFFFFFFC to 0x00000000.
                mem_addr  = {word_q + 30'd1, 2'b00};
                mem_be    = be1_q;
                mem_wdata = wd1_q;
            end
`endif
            StDone: begin
                st_done = 1'b1;
                st_err  = err_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule
